// File: rtl/carry_resolve_serial.sv
// Serial carry resolver: takes propagate/generate vectors from a half-adder
// array and ripples the carry one bit per clock to form sum and carry-out.
module carry_resolve_serial #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] p,
  input  logic [N-1:0] g,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         carry_out,
  output logic         busy
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   p_q, p_d, g_q, g_d, res_q, res_d;
  logic           c_q, c_d, co_q, co_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           c_nxt;

  assign c_nxt = g_q[idx_q] | (p_q[idx_q] & c_q);

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    g_d     = g_q;
    res_d   = res_q;
    c_d     = c_q;
    co_d    = co_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          p_d     = p;
          g_d     = g;
          c_d     = cin;
          idx_d   = '0;
          res_d   = '0;
          co_d    = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d[idx_q] = p_q[idx_q] ^ c_q;
        c_d          = c_nxt;
        // Index stops at N-1 rather than wrapping; the next accept clears it.
        if (idx_q == IW'(N - 1)) begin
          co_d    = c_nxt;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      p_q     <= '0;
      g_q     <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      co_q    <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      g_q     <= g_d;
      res_q   <= res_d;
      c_q     <= c_d;
      co_q    <= co_d;
      idx_q   <= idx_d;
    end
  end

  // Handshake outputs depend on registered state only.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = res_q;
  assign carry_out = co_q;

endmodule
